xw_counter_univ: RTL and testbench
==================================

# xw_counter_univ

Parametrised synchronous counter, the next generation of the team's 4-bit 74x163-style counter. It generalises width and modulus, adds up/down counting, wrap or saturate behaviour, and a registered wrap pulse. ENP/ENT cascade semantics and the combinational RCO are kept so stages can be chained. The block is used in the lab designs as a timebase, divider and event counter.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (2..32)
- MODULUS, 16, count range 0..MODULUS-1 (2..2^WIDTH)
- WRAP, 1, 1 = wrap at terminal count; 0 = hold at terminal count

Ports:
- CLK  input  1  clock, rising edge active
- RST  input  1  asynchronous, active-high reset
- CLR_L  input  1  synchronous clear, active low
- LD_L  input  1  synchronous parallel load, active low
- ENP  input  1  count enable (parallel)
- ENT  input  1  count enable (trickle); also gates RCO
- UP  input  1  1 = count up, 0 = count down
- D  input  WIDTH  load value
- Q  output  WIDTH  count value (registered)
- RCO  output  1  ripple carry out (combinational)
- TC  output  1  terminal count flag (combinational, ungated)
- WRAP_P  output  1  registered one-cycle pulse when a wrap occurs

## Operation
- Priority per rising CLK edge: RST (asynchronous) > CLR_L=0 > LD_L=0 > count (ENP & ENT) > hold.
- Clear: Q <= 0.
- Load: Q <= D. D is loaded as given, even when D >= MODULUS.
- Count up: if Q >= MODULUS-1, Q <= 0 when WRAP=1, else Q holds; otherwise Q <= Q+1.
- Count down: if Q == 0, Q <= MODULUS-1 when WRAP=1, else Q holds; if Q > MODULUS-1, Q <= MODULUS-1; otherwise Q <= Q-1.
- TC = UP ? (Q == MODULUS-1) : (Q == 0). An out-of-range Q never asserts TC.
- RCO = ENT & TC. It is independent of ENP, CLR_L and LD_L, matching 74x163 cascade behaviour.
- WRAP_P <= 1 on an edge where a count step takes Q from a terminal or out-of-range value to the wrap value, with WRAP=1. Otherwise WRAP_P <= 0. Clear and load never set WRAP_P.
- With WRAP=0, WRAP_P is constant 0.
- Arithmetic is WIDTH bits wide. MODULUS-1 is compared at WIDTH bits, so MODULUS = 2^WIDTH gives a natural binary wrap.
- UP may change on any cycle. The next edge uses the current UP value.

## Timing
- Reset values: Q = 0 and WRAP_P = 0. TC and RCO follow from Q: with UP=0 after reset, TC = 1 and RCO = ENT.
- Asserting RST mid-count forces Q = 0 immediately, without waiting for an edge.
- RST deassertion is synchronised externally. The first active edge after release obeys the priority list.
- Count latency: Q updates 1 cycle after the enabling edge. WRAP_P is high during the cycle after the wrapping edge, aligned with Q showing the wrap value.
- TC and RCO are combinational from Q, UP and ENT, with no register stage. Cascaded stages therefore share CLK, and the next stage's ENT is fed from this stage's RCO.
- Simultaneous CLR_L=0 and LD_L=0: clear wins.
- LD_L=0 together with counting enabled: load wins and WRAP_P = 0.

## Structure
- Shared package xw_counter_pkg holds:
  - the UP/DOWN mode constants (MODE_UP = 1, MODE_DOWN = 0)
  - the WRAP/SATURATE constants
  - a function computing the terminal value for given WIDTH and MODULUS
- One sub-module, xw_counter_next, is purely combinational. It takes Q, UP and the parameters and produces next_q, tc and wrap_evt.
- The top level holds the Q and WRAP_P registers and the priority mux.

## Test plan
- WIDTH=4, MODULUS=10, UP=1, ENP=ENT=1 from reset, 12 clocks. Required: Q runs 0..9, 0, 1. TC and RCO are high only while Q=9. WRAP_P is high exactly in the cycle Q returns to 0.
- UP=0, load D=3, then count 5 clocks. Required: Q = 3, 2, 1, 0, 9, 8. RCO is high while Q=0. Set ENT=0 while Q=0: RCO drops to 0 and Q holds.
- WRAP=0, UP=1, MODULUS=10 with Q at 9. Required: Q stays 9 for 3 clocks, TC stays 1, WRAP_P stays 0. Switch to UP=0: Q counts 8, 7.
- Load D=13 with MODULUS=10, WIDTH=4. Required with UP=1: the next Q is 0 with a WRAP_P pulse. Reload D=13 with UP=0: the next Q is 9 with no WRAP_P.
- Priority checks:
  - CLR_L=0 and LD_L=0 together, D=5: Q = 0.
  - LD_L=0 with count enabled: Q = D.
  - ENP=0, ENT=1 at Q=9 with UP=1: Q holds and RCO = 1.
  - Assert RST mid-count with no clock edge: Q = 0 immediately and WRAP_P = 0.
- Cascade two instances, WIDTH=4 and MODULUS=16, with stage 2 ENT driven by stage 1 RCO, from 0. Required: the 8-bit combined value reads 0x10 after 16 clocks and 0x00 after 256 clocks.

Source files
------------

// File: rtl/xw_counter_pkg.sv
// ============================================================================
// Module      : xw_counter_pkg
// Description : Shared constants and terminal-value helper for xw_counter_univ
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package xw_counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    localparam bit WRAP_EN  = 1'b1;
    localparam bit SATURATE = 1'b0;

    // MODULUS-1 reduced to WIDTH bits, so MODULUS = 2^WIDTH yields all-ones.
    function automatic logic [31:0] term_val(input int width, input longint modulus);
        logic [63:0] w_m;
        w_m = 64'(modulus) - 64'd1;
        w_m = w_m & ((64'd1 << width) - 64'd1);
        return w_m[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/xw_counter_next.sv
// ============================================================================
// Module      : xw_counter_next
// Description : Combinational next-count, terminal-count and wrap-event logic
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module xw_counter_next
    import xw_counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter bit     WRAP    = 1'b1
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_tc,
    output logic             o_wrap_evt
);

    localparam logic [31:0]      c_TERM32  = term_val(WIDTH, MODULUS);
    localparam logic [WIDTH-1:0] c_TERM    = c_TERM32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               c_WRAP_ON = (WRAP == WRAP_EN);

    always_comb begin
        o_next_q   = i_q;
        o_wrap_evt = 1'b0;
        if (i_up == MODE_UP) begin
            if (i_q >= c_TERM) begin
                o_next_q   = c_WRAP_ON ? '0 : i_q;
                o_wrap_evt = c_WRAP_ON;
            end else begin
                o_next_q = i_q + c_ONE;
            end
        end else begin
            // Out-of-range values snap to the terminal value; that is not a wrap.
            if (i_q == '0) begin
                o_next_q   = c_WRAP_ON ? c_TERM : i_q;
                o_wrap_evt = c_WRAP_ON;
            end else if (i_q > c_TERM) begin
                o_next_q = c_TERM;
            end else begin
                o_next_q = i_q - c_ONE;
            end
        end
    end

    assign o_tc = (i_up == MODE_UP) ? (i_q == c_TERM) : (i_q == '0);

endmodule

`default_nettype wire

// File: rtl/xw_counter_univ.sv
// ============================================================================
// Module      : xw_counter_univ
// Description : Parametrised up/down 74x163-style counter with wrap pulse
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module xw_counter_univ
    import xw_counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter bit     WRAP    = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR_L,
    input  logic             LD_L,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC,
    output logic             WRAP_P
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap_p;
    logic [WIDTH-1:0] w_next_q;
    logic             w_tc;
    logic             w_wrap_evt;

    xw_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .WRAP    (WRAP)
    ) u_next (
        .i_q        (r_q),
        .i_up       (UP),
        .o_next_q   (w_next_q),
        .o_tc       (w_tc),
        .o_wrap_evt (w_wrap_evt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q      <= '0;
            r_wrap_p <= 1'b0;
        end else if (!CLR_L) begin
            r_q      <= '0;
            r_wrap_p <= 1'b0;
        end else if (!LD_L) begin
            r_q      <= D;
            r_wrap_p <= 1'b0;
        end else if (ENP && ENT) begin
            r_q      <= w_next_q;
            r_wrap_p <= w_wrap_evt;
        end else begin
            r_wrap_p <= 1'b0;
        end
    end

    assign Q      = r_q;
    assign WRAP_P = r_wrap_p;
    assign TC     = w_tc;
    // Ungated by ENP/CLR_L/LD_L so a following stage sees carry as in a 74x163 chain.
    assign RCO    = ENT & w_tc;

endmodule

`default_nettype wire

// File: tb/tb_xw_counter_univ.sv
// ============================================================================
// Module      : tb_xw_counter_univ
// Description : Directed self-checking bench for xw_counter_univ
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xw_counter_univ;

    logic       clk;
    logic       rst;

    logic       m_clr_l, m_ld_l, m_enp, m_ent, m_up;
    logic [3:0] m_d, m_q;
    logic       m_rco, m_tc, m_wp;

    logic       s_clr_l, s_ld_l, s_up;
    logic [3:0] s_d, s_q;
    logic       s_rco, s_tc, s_wp;

    logic       c_clr_l;
    logic [3:0] c1_q, c2_q;
    logic       c1_rco, c1_tc, c1_wp, c2_rco, c2_tc, c2_wp;

    int n_checks = 0;
    int n_fail   = 0;

    xw_counter_univ #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_dut (
        .CLK(clk), .RST(rst), .CLR_L(m_clr_l), .LD_L(m_ld_l), .ENP(m_enp),
        .ENT(m_ent), .UP(m_up), .D(m_d), .Q(m_q), .RCO(m_rco), .TC(m_tc),
        .WRAP_P(m_wp)
    );

    xw_counter_univ #(.WIDTH(4), .MODULUS(10), .WRAP(1'b0)) u_sat (
        .CLK(clk), .RST(rst), .CLR_L(s_clr_l), .LD_L(s_ld_l), .ENP(1'b1),
        .ENT(1'b1), .UP(s_up), .D(s_d), .Q(s_q), .RCO(s_rco), .TC(s_tc),
        .WRAP_P(s_wp)
    );

    xw_counter_univ #(.WIDTH(4), .MODULUS(16), .WRAP(1'b1)) u_c1 (
        .CLK(clk), .RST(rst), .CLR_L(c_clr_l), .LD_L(1'b1), .ENP(1'b1),
        .ENT(1'b1), .UP(1'b1), .D(4'd0), .Q(c1_q), .RCO(c1_rco), .TC(c1_tc),
        .WRAP_P(c1_wp)
    );

    xw_counter_univ #(.WIDTH(4), .MODULUS(16), .WRAP(1'b1)) u_c2 (
        .CLK(clk), .RST(rst), .CLR_L(c_clr_l), .LD_L(1'b1), .ENP(1'b1),
        .ENT(c1_rco), .UP(1'b1), .D(4'd0), .Q(c2_q), .RCO(c2_rco), .TC(c2_tc),
        .WRAP_P(c2_wp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_clr_l = 1'b1; m_ld_l = 1'b1; m_enp = 1'b1; m_ent = 1'b1; m_up = 1'b0; m_d = 4'd0;
        s_clr_l = 1'b1; s_ld_l = 1'b1; s_up = 1'b1; s_d = 4'd0;
        c_clr_l = 1'b0;
        tick();
        tick();

        // Reset state, UP=0
        chk("rst_q", m_q, 0);
        chk("rst_wp", m_wp, 0);
        chk("rst_tc", m_tc, 1);
        chk("rst_rco", m_rco, 1);
        rst = 1'b0;
        m_up = 1'b1;
        #1;
        chk("rst_tc_up", m_tc, 0);

        // Up count mod 10
        for (int i = 1; i <= 11; i++) begin
            int e;
            e = i % 10;
            tick();
            chk("t1_q", m_q, e);
            chk("t1_tc", m_tc, (e == 9) ? 1 : 0);
            chk("t1_rco", m_rco, (e == 9) ? 1 : 0);
            chk("t1_wp", m_wp, (i == 10) ? 1 : 0);
        end

        // Down count after load 3
        m_up = 1'b0; m_ld_l = 1'b0; m_d = 4'd3;
        tick(); chk("t2_ld", m_q, 3);
        m_ld_l = 1'b1;
        tick(); chk("t2_q2", m_q, 2);
        tick(); chk("t2_q1", m_q, 1);
        tick(); chk("t2_q0", m_q, 0); chk("t2_rco0", m_rco, 1);
        m_ent = 1'b0;
        #1; chk("t2_rco_ent0", m_rco, 0);
        tick(); chk("t2_hold", m_q, 0);
        m_ent = 1'b1;
        tick(); chk("t2_q9", m_q, 9); chk("t2_wp9", m_wp, 1);
        tick(); chk("t2_q8", m_q, 8); chk("t2_wp8", m_wp, 0);

        // Saturating instance
        s_up = 1'b1; s_ld_l = 1'b0; s_d = 4'd9;
        tick(); s_ld_l = 1'b1;
        chk("t3_ld", s_q, 9); chk("t3_tc", s_tc, 1);
        repeat (3) begin
            tick();
            chk("t3_hold_q", s_q, 9); chk("t3_hold_tc", s_tc, 1); chk("t3_hold_wp", s_wp, 0);
        end
        s_up = 1'b0;
        tick(); chk("t3_dn8", s_q, 8);
        tick(); chk("t3_dn7", s_q, 7);

        // Out-of-range load
        m_up = 1'b1; m_ld_l = 1'b0; m_d = 4'd13;
        tick(); chk("t4_ld13", m_q, 13); chk("t4_tc13", m_tc, 0);
        m_ld_l = 1'b1;
        tick(); chk("t4_up_q", m_q, 0); chk("t4_up_wp", m_wp, 1);
        m_up = 1'b0; m_ld_l = 1'b0;
        tick(); chk("t4_ld13b", m_q, 13); chk("t4_rco13", m_rco, 0);
        m_ld_l = 1'b1;
        tick(); chk("t4_dn_q", m_q, 9); chk("t4_dn_wp", m_wp, 0);

        // Priority
        m_clr_l = 1'b0; m_ld_l = 1'b0; m_d = 4'd5;
        tick(); chk("p_clr_ld", m_q, 0);
        m_clr_l = 1'b1; m_up = 1'b1; m_d = 4'd9;
        tick(); chk("p_ld9", m_q, 9);
        m_d = 4'd7;
        tick(); chk("p_ld_over_cnt", m_q, 7); chk("p_ld_wp", m_wp, 0);
        m_d = 4'd9;
        tick(); m_ld_l = 1'b1; m_enp = 1'b0;
        tick(); chk("p_enp0_q", m_q, 9); chk("p_enp0_rco", m_rco, 1); chk("p_enp0_wp", m_wp, 0);
        m_enp = 1'b1;
        tick(); chk("p_wrap_q", m_q, 0); chk("p_wrap_wp", m_wp, 1);
        m_up = 1'b0;
        tick(); chk("p_dwrap_q", m_q, 9); chk("p_dwrap_wp", m_wp, 1);
        #2 rst = 1'b1;
        #1;
        chk("p_async_q", m_q, 0); chk("p_async_wp", m_wp, 0);
        #2 rst = 1'b0;

        // Cascade of two mod-16 stages
        tick(); c_clr_l = 1'b1;
        chk("c_start", {c2_q, c1_q}, 8'h00);
        repeat (16) tick();
        chk("c_16", {c2_q, c1_q}, 8'h10);
        repeat (239) tick();
        chk("c_255", {c2_q, c1_q}, 8'hFF);
        chk("c_255_rco2", c2_rco, 1);
        tick();
        chk("c_256", {c2_q, c1_q}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
